// File: rtl/fifo_sync_param_if.sv
// Bus bundle for fifo_sync_param: control, write data, thresholds and all
// status/read outputs. The master side drives requests, the slave is the FIFO.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  Enable;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] FIFO_data_in;
  logic [ADDR_WIDTH:0]   almost_full_thr;
  logic [ADDR_WIDTH:0]   almost_empty_thr;
  logic [DATA_WIDTH-1:0] FIFO_data_out;
  logic                  FIFO_valid;
  logic [ADDR_WIDTH:0]   FIFO_count;
  logic                  FIFO_empty;
  logic                  FIFO_full;
  logic                  FIFO_almost_empty;
  logic                  FIFO_almost_full;
  logic                  FIFO_overflow;
  logic                  FIFO_underflow;

  modport master (
    output Enable, write_enable, read_enable, FIFO_data_in,
           almost_full_thr, almost_empty_thr,
    input  FIFO_data_out, FIFO_valid, FIFO_count, FIFO_empty, FIFO_full,
           FIFO_almost_empty, FIFO_almost_full, FIFO_overflow, FIFO_underflow
  );

  modport slave (
    input  Enable, write_enable, read_enable, FIFO_data_in,
           almost_full_thr, almost_empty_thr,
    output FIFO_data_out, FIFO_valid, FIFO_count, FIFO_empty, FIFO_full,
           FIFO_almost_empty, FIFO_almost_full, FIFO_overflow, FIFO_underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO, DEPTH = 2**ADDR_WIDTH, with occupancy count, programmable
// almost-full/almost-empty thresholds, registered read port with valid strobe
// and sticky overflow/underflow flags. Reset is synchronous, active-high.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic              clk,
  input  logic              Reset,
  fifo_sync_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == {(ADDR_WIDTH+1){1'b0}});

  // Accept decisions and error events, all from the pre-edge state.
  // A write into a full FIFO is fine if a read frees a slot in the same edge;
  // a read of an empty FIFO is never accepted (no fall-through).
  always_comb begin
    w_wr_ok   = 1'b0;
    w_rd_ok   = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (bus.Enable) begin
      w_wr_ok   = bus.write_enable & (~w_full | bus.read_enable);
      w_rd_ok   = bus.read_enable & ~w_empty;
      w_ovf_evt = bus.write_enable & w_full & ~bus.read_enable;
      w_unf_evt = bus.read_enable & w_empty;
    end else begin
      w_wr_ok   = 1'b0;
      w_rd_ok   = 1'b0;
      w_ovf_evt = 1'b0;
      w_unf_evt = 1'b0;
    end
  end

  // Storage array; contents need no reset since pointers/count gate access.
  always_ff @(posedge clk) begin
    if (!Reset && w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.FIFO_data_in;
    end
  end

  // Pointers, occupancy, read port and sticky error flags.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wr_ptr    <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr    <= {ADDR_WIDTH{1'b0}};
      r_count     <= {(ADDR_WIDTH+1){1'b0}};
      r_data_out  <= {DATA_WIDTH{1'b0}};
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.Enable) begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE_C;
      end
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PTR_ONE_C;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_ONE_C;
        2'b01:   r_count <= r_count - CNT_ONE_C;
        default: r_count <= r_count;
      endcase
      r_valid <= w_rd_ok;
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end
    end else begin
      // Frozen: only the valid strobe drops, read data holds.
      r_valid <= 1'b0;
    end
  end

  assign bus.FIFO_data_out     = r_data_out;
  assign bus.FIFO_valid        = r_valid;
  assign bus.FIFO_count        = r_count;
  assign bus.FIFO_empty        = w_empty;
  assign bus.FIFO_full         = w_full;
  assign bus.FIFO_almost_empty = (r_count <= bus.almost_empty_thr);
  assign bus.FIFO_almost_full  = (r_count >= bus.almost_full_thr);
  assign bus.FIFO_overflow     = r_overflow;
  assign bus.FIFO_underflow    = r_underflow;
endmodule
